fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage with prefetch buffer; sits directly upstream of the decode stage.
//   Owns the fetch PC and issues one-outstanding requests on a req/ack instruction-memory port.
//   Buffers {pc, inst} pairs in a small FIFO and hands them to decode over valid/ready.
//   Accepts a redirect (taken branch/jump) that flushes the buffer and restarts fetch at the target.
// PARAMETERS
//   RESET_PC   32'h0000_0000  first fetch address after reset
//   DEPTH      4              prefetch FIFO entries (power of 2, >=2)
//   PTR_W      2              log2(DEPTH)
// PORTS
//   clk             in   1   clock; all state updates on posedge
//   rst_n           in   1   synchronous reset, active low
//   redirect_valid  in   1   1 = restart fetch at redirect_pc this cycle
//   redirect_pc     in   32  branch/jump target; bits [1:0] ignored (forced 0)
//   imem_req        out  1   fetch request; held high until imem_ack
//   imem_addr       out  32  word-aligned fetch address; stable while imem_req=1
//   imem_ack        in   1   memory returns imem_rdata this cycle (may coincide with req)
//   imem_rdata      in   32  instruction word, valid only when imem_ack=1
//   inst_valid      out  1   FIFO head holds a valid instruction
//   inst            out  32  head instruction word
//   pc_added        out  32  head pc + 4 (decode uses it for jump/branch targets)
//   inst_ready      in   1   decode accepts head this cycle
// BEHAVIOUR
//   Interface: one clock clk; reset rst_n synchronous, active-low; nothing asynchronous.
//   Reset: fetch_pc=RESET_PC, FIFO empty, state=FETCH; imem_req=0, imem_addr=RESET_PC,
//     inst_valid=0, inst=0, pc_added=0. imem_req first rises the cycle after rst_n samples 1.
//   FSM: FETCH (normal) / DISCARD (draining a stale in-flight request after redirect).
//   Issue rule (FETCH): imem_req=1 when count + outstanding < DEPTH; imem_addr=fetch_pc.
//     Once raised, req and addr hold until imem_ack, regardless of inst_ready.
//   Ack in FETCH, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (32-bit wrap,
//     32'hFFFF_FFFC -> 0). Next request may issue the following cycle.
//   Latency: ack in cycle N -> inst_valid=1 in N+1 (FIFO empty, no redirect).
//   Pop: inst_valid & inst_ready -> head advances at posedge; push+pop same cycle legal,
//     count unchanged. Empty: inst_valid=0, inst/pc_added hold last value (don't-care).
//   Full: no new req issued; data already requested is always accepted (space reserved).
//   Redirect (priority over push/pop): FIFO flushed (count=0), pop ignored,
//     fetch_pc={redirect_pc[31:2],2'b00}.
//     - no request outstanding, or ack this same cycle: ack data dropped, stay FETCH,
//       new req to target next cycle.
//     - request outstanding, no ack: -> DISCARD; req/addr keep old value until ack;
//       that data dropped; -> FETCH, request target the following cycle.
//     - redirect while in DISCARD: update fetch_pc to newest target, stay DISCARD.
//   inst_valid=0 the cycle after any redirect (FIFO empty).
//   Reset mid-request: all state cleared, req dropped; memory must tolerate abandon.
// STRUCTURE
//   Shared header cpu_defs.vh: `RESET_PC, `INST_W=32, `ADDR_W=32, FSM state encodings.
//   Sub-module fetch_fifo: sync FIFO, DEPTH x 64 bits, push/pop/flush, count output.
//   fetch_unit holds fetch_pc, outstanding flag, FSM, issue logic; drives decode from FIFO head.
// TESTING
//   1 Reset release, ack same cycle as req, inst_ready=1 -> inst pc 0,4,8,... one per cycle;
//     first inst_valid 1 cycle after first ack, pc_added=4.
//   2 inst_ready=0 for 10 cycles -> exactly 4 acks accepted, then imem_req=0;
//     ready=1 -> words drain in order, fetching resumes when count+outstanding<4.
//   3 Ack delayed 3 cycles, redirect_pc=32'h100 in cycle 1 of wait -> imem_addr holds old
//     value until ack, data dropped, next req addr=32'h100, first inst pc=32'h100.
//   4 Redirect in same cycle as ack and pop with 2 entries -> FIFO empty, ack data lost,
//     inst_valid=0 next cycle, next req addr=target.
//   5 redirect_pc=32'h203 -> imem_addr=32'h200; fetch_pc 32'hFFFF_FFFC -> next addr 32'h0.
//   6 rst_n=0 with req outstanding and 3 entries -> next cycle imem_req=0,
//     inst_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage: data widths, default
//   parameters, FSM state encoding, the prefetch-buffer entry layout and a
//   word-alignment helper.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int                DEFAULT_DEPTH    = 4;
  localparam int                DEFAULT_PTR_W    = 2;

  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_e;

  // The buffer keeps pc+4 rather than pc: decode only ever needs pc+4, and a
  // zero-reset entry then reads back as pc_added=0 straight out of reset.
  typedef struct packed {
    logic [ADDR_W-1:0] pc_added;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_unit_fifo
//   Synchronous prefetch FIFO of {pc_added, inst} entries with push, pop and
//   flush. Head entry is presented combinationally; count is registered.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     push         write push_data at tail (caller guarantees not full)
//     push_data    entry to write
//     pop          advance head (caller guarantees not empty)
//     flush        drop all entries; wins over push/pop
//     head         current head entry (stale when count==0)
//     count        number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = DEFAULT_PTR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  fetch_entry_t   push_data,
  input  logic           pop,
  input  logic           flush,
  output fetch_entry_t   head,
  output logic [PTR_W:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the fetch PC, issues one outstanding request
//   at a time to instruction memory, buffers returned words in a prefetch FIFO
//   and hands them to decode over valid/ready. A redirect flushes the buffer
//   and restarts fetch at the (word-aligned) target.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     redirect_valid   restart fetch at redirect_pc this cycle
//     redirect_pc      redirect target, low two bits ignored
//     imem_req         fetch request, held until imem_ack
//     imem_addr        word-aligned fetch address, stable while imem_req=1
//     imem_ack         memory returns imem_rdata this cycle
//     imem_rdata       instruction word, valid with imem_ack
//     inst_valid       FIFO head holds an instruction
//     inst             head instruction word
//     pc_added         head pc + 4
//     inst_ready       decode accepts head this cycle
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_FETCH   | normal operation; acked data is pushed into the FIFO
//   ST_DISCARD | redirect arrived with a request in flight; its data is
//              | dropped when it returns, then fetch resumes at the target
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter int          PTR_W    = DEFAULT_PTR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_added,
  input  logic        inst_ready
);

  fetch_state_e   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    addr_q, addr_d;
  logic           req_q, req_d;
  logic [31:0]    pc_plus4;
  logic           pending;
  logic           push, pop, flush;
  logic [PTR_W:0] count, count_d;
  fetch_entry_t   push_data, head;
  logic           unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_plus4  = fetch_pc_q + 32'd4;
  // Request still in flight after this edge.
  assign pending   = req_q & ~imem_ack;
  assign push_data = {pc_plus4, imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    count_d    = count;

    if (redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_d = word_align(redirect_pc);
      state_d    = pending ? ST_DISCARD : ST_FETCH;
    end else begin
      pop = inst_valid & inst_ready;
      if (req_q && imem_ack) begin
        if (state_q == ST_FETCH) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
        end else begin
          state_d = ST_FETCH;
        end
      end
    end

    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count + 1'b1;
    end else if (pop && !push) begin
      count_d = count - 1'b1;
    end

    // A new request is only launched once nothing is in flight, so
    // occupancy alone decides whether there is room. DEPTH is a power of
    // two, so the count MSB is set exactly when the FIFO is full.
    if (!pending) begin
      req_d  = (state_d == ST_FETCH) && !count_d[PTR_W];
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign pc_added   = head.pc_added;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_added;
  logic        inst_ready;

  int   checks   = 0;
  int   failures = 0;
  logic mem_en;
  int   ack_delay;

  typedef struct {
    logic [31:0] pc_added;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .PTR_W    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc_added       (pc_added),
    .inst_ready     (inst_ready)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc_added = pc + 32'd4;
    e.inst     = word_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 200);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: %0d instructions not delivered, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    mem_en         = 1'b1;
    ack_delay      = 0;
    repeat (3) tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Instruction memory model: acks after ack_delay waiting cycles.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req && mem_en) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: got pc_added=%h inst=%h, required no output at t=%0t",
                 pc_added, inst, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst_pc_added", pc_added, e.pc_added);
        check("inst_word", inst, e.inst);
      end
    end
  end

  // Request protocol: req and addr hold until ack.
  logic        pend_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;
  always @(negedge clk) begin
    if (rst_n && pend_prev) begin
      check("req_held", {31'b0, imem_req}, 32'd1);
      if (imem_req) check("addr_stable", imem_addr, addr_prev);
    end
    pend_prev = rst_n && imem_req && !imem_ack;
    addr_prev = imem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    mem_en         = 1'b1;
    ack_delay      = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc_added", pc_added, 32'h0);

    // 1: streaming, ack same cycle as req
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
    tick();
    @(negedge clk);
    check("t1_first_req", {31'b0, imem_req}, 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_c1", {31'b0, inst_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("t1_valid_c2", {31'b0, inst_valid}, 32'd1);
    drain("t1");
    inst_ready = 1'b0;

    // 2: decode stalled, FIFO fills to 4 and fetch stops
    do_reset();
    tick();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) acks++;
      tick();
    end
    check("t2_acks", acks, 32'd4);
    @(negedge clk);
    check("t2_req_full", {31'b0, imem_req}, 32'd0);
    check("t2_valid_full", {31'b0, inst_valid}, 32'd1);
    tick();
    for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
    inst_ready = 1'b1;
    @(negedge clk);
    check("t2_req_still_full", {31'b0, imem_req}, 32'd0);
    tick();
    @(negedge clk);
    check("t2_resume_req", {31'b0, imem_req}, 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    drain("t2");
    inst_ready = 1'b0;

    // 3: redirect while a slow request is in flight
    do_reset();
    inst_ready = 1'b1;
    ack_delay  = 3;
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("t3_req_c1", {31'b0, imem_req}, 32'd1);
    check("t3_addr_c1", imem_addr, 32'h0);
    tick();
    redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t3_addr_hold", imem_addr, 32'h0);
      tick();
    end
    ack_delay = 0;
    @(negedge clk);
    check("t3_new_req", {31'b0, imem_req}, 32'd1);
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_valid_c5", {31'b0, inst_valid}, 32'd0);
    drain("t3");
    inst_ready = 1'b0;

    // 4: redirect coinciding with ack and pop, two entries buffered
    do_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    @(negedge clk);
    check("t4_valid_pre", {31'b0, inst_valid}, 32'd1);
    check("t4_ack_same", {31'b0, imem_req & imem_ack}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(negedge clk);
    check("t4_valid_after", {31'b0, inst_valid}, 32'd0);
    check("t4_req", {31'b0, imem_req}, 32'd1);
    check("t4_addr", imem_addr, 32'h40);
    tick();
    push_exp(32'h40);
    push_exp(32'h44);
    push_exp(32'h48);
    inst_ready = 1'b1;
    drain("t4");
    inst_ready = 1'b0;

    // 5: target alignment and pc wrap
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t5_align_req", {31'b0, imem_req}, 32'd1);
    check("t5_align_addr", imem_addr, 32'h200);
    tick();
    redirect_valid = 1'b0;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    push_exp(32'h4);
    inst_ready = 1'b1;
    @(negedge clk);
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("t5_wrap_req", {31'b0, imem_req}, 32'd1);
    check("t5_wrap_addr", imem_addr, 32'h0);
    drain("t5");
    inst_ready = 1'b0;

    // 6: reset with a request outstanding and three entries buffered
    do_reset();
    tick();
    tick();
    tick();
    tick();
    mem_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("t6_req_pend", {31'b0, imem_req}, 32'd1);
    check("t6_addr_pend", imem_addr, 32'hC);
    check("t6_valid_pend", {31'b0, inst_valid}, 32'd1);
    tick();
    @(negedge clk);
    check("t6_req_rst", {31'b0, imem_req}, 32'd0);
    check("t6_valid_rst", {31'b0, inst_valid}, 32'd0);
    check("t6_addr_rst", imem_addr, 32'h0);
    check("t6_inst_rst", inst, 32'h0);
    check("t6_pc_added_rst", pc_added, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
